// File: rtl/alu_arbiter.sv
// Round-robin controller that shares one combinational 32-bit ALU between two
// requesters, decoding MIPS R-type funct codes and returning each result to its owner.
module alu_arbiter #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [5:0]  req0_funct,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [5:0]  req1_funct,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  output logic        rsp1_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  input  logic [31:0] alu_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [5:0] FN_SLL = 6'd0,  FN_SRL = 6'd2,  FN_MUL = 6'd24,
                         FN_ADD = 6'd32, FN_AND = 6'd36, FN_OR  = 6'd37,
                         FN_XOR = 6'd38, FN_NOR = 6'd39;
  localparam logic [3:0] MUL_COUNT = 4'(MUL_LAT - 1);

  state_t      state, state_nxt;
  logic        last_grant;
  logic        owner;
  logic        err_q;
  logic [3:0]  count;

  logic        grant_valid;
  logic        grant;
  logic [5:0]  hs_funct;
  logic [31:0] hs_a, hs_b;
  logic [2:0]  dec_sel;
  logic        dec_err;

  // Grant only exists in IDLE; a tie goes to whoever did not win last time.
  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant       = 1'b0;
    if (state == IDLE) begin
      unique case ({req1_valid, req0_valid})
        2'b01:   begin grant_valid = 1'b1; grant = 1'b0;        end
        2'b10:   begin grant_valid = 1'b1; grant = 1'b1;        end
        2'b11:   begin grant_valid = 1'b1; grant = ~last_grant; end
        default: ;
      endcase
    end
  end

  assign req0_ready = grant_valid && !grant;
  assign req1_ready = grant_valid &&  grant;

  assign hs_funct = grant ? req1_funct : req0_funct;
  assign hs_a     = grant ? req1_a     : req0_a;
  assign hs_b     = grant ? req1_b     : req0_b;

  always_comb begin
    dec_err = 1'b0;
    unique case (hs_funct)
      FN_ADD:  dec_sel = 3'b000;
      FN_MUL:  dec_sel = 3'b001;
      FN_AND:  dec_sel = 3'b010;
      FN_OR:   dec_sel = 3'b011;
      FN_XOR:  dec_sel = 3'b100;
      FN_NOR:  dec_sel = 3'b101;
      FN_SLL:  dec_sel = 3'b110;
      FN_SRL:  dec_sel = 3'b111;
      default: begin dec_sel = 3'b000; dec_err = 1'b1; end
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_valid) state_nxt = EXEC;
      EXEC:    if (count == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      err_q      <= 1'b0;
      count      <= 4'd0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp0_data  <= '0;
      rsp0_err   <= 1'b0;
      rsp1_data  <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            alu_a      <= hs_a;
            alu_b      <= hs_b;
            alu_sel    <= dec_sel;
            err_q      <= dec_err;
            owner      <= grant;
            last_grant <= grant;
            count      <= (hs_funct == FN_MUL) ? MUL_COUNT : 4'd0;
          end
        end
        EXEC: begin
          // The per-requester data registers double as the result register,
          // so each requester's last result survives the other's traffic.
          if (count == 4'd0) begin
            if (owner) begin
              rsp1_data <= err_q ? 32'd0 : alu_out;
              rsp1_err  <= err_q;
            end else begin
              rsp0_data <= err_q ? 32'd0 : alu_out;
              rsp0_err  <= err_q;
            end
          end else begin
            count <= count - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) &&  owner;
  assign busy       = (state != IDLE);

endmodule
